// File: rtl/alu_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl_pkg
// Description : Shared types and default widths for the shared-ALU controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_share_ctrl_pkg;

    localparam int c_OP_WIDTH  = 16;
    localparam int c_OUT_WIDTH = 32;
    localparam int c_FUN_WIDTH = 4;
    localparam int c_TIMEOUT   = 8;

    // Controller state; encoding is fixed so waveforms match the ALU docs.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    // ALU_FUN[3:2] unit select as decoded inside the ALU top.
    typedef enum logic [1:0] {
        UNIT_ARITH = 2'b00,
        UNIT_LOGIC = 2'b01,
        UNIT_CMP   = 2'b10,
        UNIT_SHIFT = 2'b11
    } alu_unit_e;

endpackage
`default_nettype wire

// File: rtl/alu_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl_if
// Description : Requester, ALU and response buses around the shared-ALU
//               controller. slave = controller side, master = environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_ctrl_if #(
    parameter int OP_WIDTH  = alu_share_ctrl_pkg::c_OP_WIDTH,
    parameter int OUT_WIDTH = alu_share_ctrl_pkg::c_OUT_WIDTH,
    parameter int FUN_WIDTH = alu_share_ctrl_pkg::c_FUN_WIDTH
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [OP_WIDTH-1:0]  req0_a;
    logic [OP_WIDTH-1:0]  req0_b;
    logic [FUN_WIDTH-1:0] req0_fun;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [OP_WIDTH-1:0]  req1_a;
    logic [OP_WIDTH-1:0]  req1_b;
    logic [FUN_WIDTH-1:0] req1_fun;

    logic [OP_WIDTH-1:0]  alu_a;
    logic [OP_WIDTH-1:0]  alu_b;
    logic [FUN_WIDTH-1:0] alu_fun;
    logic                 alu_en;
    logic [OUT_WIDTH-1:0] alu_out;
    logic                 alu_out_valid;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [OUT_WIDTH-1:0] rsp_data;
    logic                 rsp_err;
    logic                 busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fun,
        input  req1_valid, req1_a, req1_b, req1_fun,
        input  alu_out, alu_out_valid, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_fun, alu_en,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_fun,
        output req1_valid, req1_a, req1_b, req1_fun,
        output alu_out, alu_out_valid, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_fun, alu_en,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

endinterface
`default_nettype wire

// File: rtl/alu_share_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl_rr_arb2
// Description : Combinational two-way round-robin grant.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl_rr_arb2 (
    input  wire logic [1:0] valid_i,
    input  wire logic       last_grant_i,
    output logic            grant_o,
    output logic            any_valid_o
);

    // A tie goes to the requester that did not win last; else the lone one.
    always_comb begin
        any_valid_o = |valid_i;
        if (&valid_i) begin
            grant_o = ~last_grant_i;
        end else begin
            grant_o = valid_i[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_ctrl
// Description : Shares one registered-result ALU between two requesters.
//               One op in flight at a time: grant, issue, wait, respond.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int OP_WIDTH  = c_OP_WIDTH,
    parameter int OUT_WIDTH = c_OUT_WIDTH,
    parameter int FUN_WIDTH = c_FUN_WIDTH,
    parameter int TIMEOUT   = c_TIMEOUT
) (
    input  wire logic        clk_i,
    input  wire logic        rst_n_i,
    alu_share_ctrl_if.slave  bus
);

    localparam int             CW         = $clog2(TIMEOUT);
    localparam logic [CW-1:0]  c_CNT_LAST = CW'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic                 last_grant_q;
    logic [CW-1:0]        cnt_q;
    logic [OP_WIDTH-1:0]  alu_a_q, alu_b_q;
    logic [FUN_WIDTH-1:0] alu_fun_q;
    logic                 rsp_id_q;
    logic [OUT_WIDTH-1:0] rsp_data_q;
    logic                 rsp_err_q;

    logic                 w_grant;
    logic                 w_any;

    alu_share_ctrl_rr_arb2 u_arb (
        .valid_i      ({bus.req1_valid, bus.req0_valid}),
        .last_grant_i (last_grant_q),
        .grant_o      (w_grant),
        .any_valid_o  (w_any)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and combinational strobes/handshakes.
    always_comb begin
        state_d        = state_q;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.alu_en     = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.busy       = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                bus.req0_ready = w_any && !w_grant;
                bus.req1_ready = w_any &&  w_grant;
                if (w_any) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.alu_en = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.alu_out_valid || (cnt_q == c_CNT_LAST)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture at the grant, wait counter, and response capture;
    // a valid result wins over a timeout that lands in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_fun_q    <= '0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_any) begin
                        alu_a_q      <= w_grant ? bus.req1_a   : bus.req0_a;
                        alu_b_q      <= w_grant ? bus.req1_b   : bus.req0_b;
                        alu_fun_q    <= w_grant ? bus.req1_fun : bus.req0_fun;
                        rsp_id_q     <= w_grant;
                        last_grant_q <= w_grant;
                    end
                end
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (bus.alu_out_valid) begin
                        rsp_data_q <= bus.alu_out;
                        rsp_err_q  <= 1'b0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_a    = alu_a_q;
    assign bus.alu_b    = alu_b_q;
    assign bus.alu_fun  = alu_fun_q;
    assign bus.rsp_id   = rsp_id_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_ctrl
// Description : Self-checking bench for alu_share_ctrl with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_ctrl;

    localparam int OPW  = 16;
    localparam int OUTW = 32;
    localparam int FUNW = 4;
    localparam int TMO  = 8;

    typedef struct {
        bit          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  f;
        logic [31:0] data;
    } txn_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.OP_WIDTH(OPW), .OUT_WIDTH(OUTW), .FUN_WIDTH(FUNW)) bus ();

    alu_share_ctrl #(
        .OP_WIDTH (OPW),
        .OUT_WIDTH(OUTW),
        .FUN_WIDTH(FUNW),
        .TIMEOUT  (TMO)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          m_last;          // requester the model expects won last
    logic        alu_drop = 1'b0; // ALU model swallows results when set
    logic        stray = 1'b0;
    logic [31:0] stray_data = '0;
    logic        model_valid;
    logic [31:0] model_out;
    logic [15:0] last_a, last_b;
    logic [3:0]  last_f;
    logic [31:0] last_data;

    assign bus.alu_out_valid = model_valid | stray;
    assign bus.alu_out       = stray ? stray_data : model_out;

    // Behavioural ALU function: sign-extended 32-bit results.
    function automatic logic [31:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] f);
        logic signed [31:0] sa, sb;
        sa = {{16{a[15]}}, a};
        sb = {{16{b[15]}}, b};
        case (f)
            4'h0: return sa + sb;
            4'h1: return sa - sb;
            4'h2: return sa * sb;
            4'h3: return -sa;
            4'h4: return sa & sb;
            4'h5: return sa | sb;
            4'h6: return sa ^ sb;
            4'h7: return ~sa;
            4'h8: return 32'(sa < sb);
            4'h9: return 32'(sa == sb);
            4'hA: return 32'(sa > sb);
            4'hB: return 32'(sa != sb);
            4'hC: return sa << b[3:0];
            4'hD: return sa >>> b[3:0];
            4'hE: return sa >> b[3:0];
            default: return sa;
        endcase
    endfunction

    // ALU model: registered result one cycle after the issue strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_valid <= 1'b0;
            model_out   <= '0;
        end else begin
            model_valid <= bus.alu_en & ~alu_drop;
            model_out   <= alu_ref(bus.alu_a, bus.alu_b, bus.alu_fun);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_fun = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_fun = '0;
        bus.rsp_ready  = 1'b1;
    endtask

    task automatic set_req(input bit id, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] f);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_fun = f;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_fun = f;
        end
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        repeat (2) tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.busy, bus.alu_en, bus.rsp_err, bus.rsp_id,
             bus.req0_ready, bus.req1_ready} !== 7'd0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b required 0", {bus.rsp_valid, bus.busy,
                     bus.alu_en, bus.rsp_err, bus.rsp_id, bus.req0_ready, bus.req1_ready});
        end
        n_cmp++;
        if ({bus.alu_a, bus.alu_b, bus.alu_fun, bus.rsp_data} !== '0) begin
            n_bad++; $display("FAIL reset_data: alu_a=%h alu_b=%h fun=%h data=%h required 0",
                     bus.alu_a, bus.alu_b, bus.alu_fun, bus.rsp_data);
        end
        rst_n = 1'b1;
        tick();
        // Start an op from REQ0 and abort it with reset while waiting.
        alu_drop = 1'b1;
        set_req(0, 16'($urandom), 16'($urandom), 4'($urandom));
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_pre_grant: got %b required 1", bus.req0_ready);
        end
        tick(); bus.req0_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.busy, bus.alu_en, bus.rsp_err} !== 4'd0 ||
            {bus.alu_a, bus.alu_b, bus.alu_fun, bus.rsp_data} !== '0) begin
            n_bad++; $display("FAIL reset_mid_wait: vld=%b busy=%b a=%h data=%h required 0",
                     bus.rsp_valid, bus.busy, bus.alu_a, bus.rsp_data);
        end
        rst_n = 1'b1; alu_drop = 1'b0;
        set_req(0, 16'($urandom), 16'($urandom), 4'($urandom));
        set_req(1, 16'($urandom), 16'($urandom), 4'($urandom));
        #1;
        n_cmp++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            n_bad++; $display("FAIL reset_tie: got %b required 01",
                     {bus.req1_ready, bus.req0_ready});
        end
        m_last = 1'b0;
        tick(); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        n = 0;
        while (bus.busy && n < 30) begin tick(); n++; end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_drain: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_single();
        int lat;
        set_req(0, 16'hFFFB, 16'h0003, 4'h0);
        #1;
        n_cmp++;
        if (bus.req0_ready !== 1'b1) begin
            n_bad++; $display("FAIL single_ready: got %b required 1", bus.req0_ready);
        end
        m_last = 1'b0;
        tick(); bus.req0_valid = 1'b0; lat = 1;
        while (!bus.rsp_valid && lat < 20) begin tick(); lat++; end
        n_cmp++;
        if (lat !== 3) begin
            n_bad++; $display("FAIL single_latency: got %0d required 3", lat);
        end
        n_cmp++;
        if ({bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b0, 32'hFFFFFFFE, 1'b0}) begin
            n_bad++; $display("FAIL single_rsp: id=%b data=%h err=%b required 0/fffffffe/0",
                     bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end
        tick();
        n_cmp++;
        if ({bus.busy, bus.rsp_valid} !== 2'b00) begin
            n_bad++; $display("FAIL single_done: busy=%b vld=%b required 0",
                     bus.busy, bus.rsp_valid);
        end
    endtask

    task automatic test_contention();
        txn_t q[$];
        txn_t t;
        int   nrsp = 0, nen = 0;
        bit   pend = 0, pend_id = 0, prev_en = 0, g;
        logic [1:0] rdy, exp_rdy;
        bus.rsp_ready = 1'b1;
        set_req(0, 16'($urandom), 16'($urandom), 4'($urandom));
        set_req(1, 16'($urandom), 16'($urandom), 4'($urandom));
        for (int cyc = 0; cyc < 200 && nrsp < 8; cyc++) begin
            if (pend) begin
                set_req(pend_id, 16'($urandom), 16'($urandom), 4'($urandom));
                pend = 0;
            end
            #1;
            rdy = {bus.req1_ready, bus.req0_ready};
            if (rdy != 2'b00) begin
                g = ~m_last;
                exp_rdy = g ? 2'b10 : 2'b01;
                n_cmp++;
                if (rdy !== exp_rdy) begin
                    n_bad++; $display("FAIL contention_grant: got %b required %b", rdy, exp_rdy);
                end
                t.id   = g;
                t.a    = g ? bus.req1_a   : bus.req0_a;
                t.b    = g ? bus.req1_b   : bus.req0_b;
                t.f    = g ? bus.req1_fun : bus.req0_fun;
                t.data = alu_ref(t.a, t.b, t.f);
                q.push_back(t);
                m_last = g; pend = 1; pend_id = g;
            end
            if (bus.alu_en) begin
                nen++;
                n_cmp++;
                if (prev_en) begin
                    n_bad++; $display("FAIL contention_en_width: got 2+ cycles required 1");
                end
                if (q.size() > 0) begin
                    n_cmp++;
                    if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== {q[0].a, q[0].b, q[0].f}) begin
                        n_bad++; $display("FAIL contention_issue: got %h/%h/%h required %h/%h/%h",
                                 bus.alu_a, bus.alu_b, bus.alu_fun, q[0].a, q[0].b, q[0].f);
                    end
                end
            end
            prev_en = bus.alu_en;
            if (bus.rsp_valid) begin
                nrsp++;
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++; $display("FAIL contention_rsp: got unexpected response required none");
                end else begin
                    t = q.pop_front();
                    if ({bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {t.id, t.data, 1'b0}) begin
                        n_bad++; $display("FAIL contention_rsp: got id=%b data=%h err=%b required %b/%h/0",
                                 bus.rsp_id, bus.rsp_data, bus.rsp_err, t.id, t.data);
                    end
                end
            end
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        n_cmp++;
        if (nrsp != 8 || nen != 8) begin
            n_bad++; $display("FAIL contention_count: got rsp=%0d en=%0d required 8/8", nrsp, nen);
        end
        tick();
    endtask

    task automatic test_timeout();
        int lat;
        alu_drop = 1'b1;
        set_req(1, 16'($urandom), 16'($urandom), 4'($urandom));
        #1;
        n_cmp++;
        if (bus.req1_ready !== 1'b1) begin
            n_bad++; $display("FAIL timeout_ready: got %b required 1", bus.req1_ready);
        end
        m_last = 1'b1;
        tick(); bus.req1_valid = 1'b0;
        n_cmp++;
        if (bus.alu_en !== 1'b1) begin
            n_bad++; $display("FAIL timeout_issue: alu_en=%b required 1", bus.alu_en);
        end
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin tick(); lat++; end
        n_cmp++;
        if (lat !== 1 + TMO) begin
            n_bad++; $display("FAIL timeout_latency: got %0d required %0d", lat, 1 + TMO);
        end
        n_cmp++;
        if ({bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, 32'd0, 1'b1}) begin
            n_bad++; $display("FAIL timeout_rsp: id=%b data=%h err=%b required 1/0/1",
                     bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end
        alu_drop = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        bus.rsp_ready = 1'b0;
        last_a = 16'($urandom); last_b = 16'($urandom); last_f = 4'($urandom);
        last_data = alu_ref(last_a, last_b, last_f);
        set_req(0, last_a, last_b, last_f);
        m_last = 1'b0;
        tick();
        set_req(1, 16'($urandom), 16'($urandom), 4'($urandom));
        bus.req0_a = 16'($urandom);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin tick(); n++; end
        for (int i = 0; i < 10; i++) begin
            #1;
            n_cmp++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err,
                 bus.req0_ready, bus.req1_ready} !== {1'b1, 1'b0, last_data, 1'b0, 2'b00}) begin
                n_bad++; $display("FAIL backpressure_hold[%0d]: vld=%b id=%b data=%h err=%b rdy=%b%b required 1/0/%h/0/00",
                         i, bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err,
                         bus.req1_ready, bus.req0_ready, last_data);
            end
            tick();
        end
        bus.req0_valid = 1'b0; bus.rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if ({bus.busy, bus.req1_ready} !== 2'b01) begin
            n_bad++; $display("FAIL backpressure_release: busy=%b req1_ready=%b required 0/1",
                     bus.busy, bus.req1_ready);
        end
        bus.req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_stray();
        int          n;
        logic [15:0] a, b;
        logic [3:0]  f;
        logic [31:0] exp;
        stray = 1'b1; stray_data = $urandom;
        tick(); stray = 1'b0;
        tick();
        n_cmp++;
        if ({bus.busy, bus.rsp_valid} !== 2'b00 ||
            {bus.alu_a, bus.alu_b, bus.alu_fun, bus.rsp_data} !== {last_a, last_b, last_f, last_data}) begin
            n_bad++; $display("FAIL stray_idle: busy=%b a=%h b=%h data=%h required 0/%h/%h/%h",
                     bus.busy, bus.alu_a, bus.alu_b, bus.rsp_data, last_a, last_b, last_data);
        end
        bus.rsp_ready = 1'b0;
        a = 16'($urandom); b = 16'($urandom); f = 4'($urandom);
        exp = alu_ref(a, b, f);
        set_req(1, a, b, f);
        m_last = 1'b1;
        tick(); bus.req1_valid = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin tick(); n++; end
        stray = 1'b1; stray_data = ~exp;
        tick(); stray = 1'b0;
        tick();
        n_cmp++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {1'b1, 1'b1, exp, 1'b0}) begin
            n_bad++; $display("FAIL stray_resp: vld=%b id=%b data=%h err=%b required 1/1/%h/0",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err, exp);
        end
        bus.rsp_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL stray_done: busy=%b required 0", bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_timeout();
        test_backpressure();
        test_stray();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
